// File: rtl/rtr_lar_pipe.sv
// Lookahead routing stage for a phased dimension-order mesh router, followed by a
// two-entry (output + skid) elastic buffer. Define RTR_LAR_PIPE_CHECK_EN to add the
// packet framing checker that drives error.
// Layout: dimension d of an address sits at [d*dim_addr_width +: dim_addr_width];
// dest_info holds class c at [c*router_addr_width +: router_addr_width], node address on top.
module rtr_lar_pipe #(
  parameter int num_resource_classes = 2,
  parameter int num_routers_per_dim  = 4,
  parameter int num_dimensions       = 2,
  parameter int num_nodes_per_router = 1,
  localparam int dim_addr_width    = $clog2(num_routers_per_dim),
  localparam int router_addr_width = num_dimensions * dim_addr_width,
  localparam int node_addr_width   = $clog2(num_nodes_per_router),
  localparam int num_ports         = 2 * num_dimensions + num_nodes_per_router,
  localparam int dest_info_width   = num_resource_classes * router_addr_width + node_addr_width,
  localparam int lar_info_width    = $clog2(num_ports) + $clog2(num_resource_classes)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [router_addr_width-1:0] router_address,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_head,
  input  logic                         in_tail,
  input  logic [dest_info_width-1:0]   in_dest_info,
  input  logic [lar_info_width-1:0]    in_lar_info,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_head,
  output logic                         out_tail,
  output logic [dest_info_width-1:0]   out_dest_info,
  output logic [lar_info_width-1:0]    out_lar_info,
  output logic                         error
);

  localparam int port_width      = $clog2(num_ports);
  localparam int rc_width        = $clog2(num_resource_classes);
  localparam int node_width_safe = (node_addr_width > 0) ? node_addr_width : 1;

  typedef logic [port_width-1:0]        port_t;
  typedef logic [rc_width-1:0]          rc_t;
  typedef logic [router_addr_width-1:0] addr_t;
  typedef logic [dim_addr_width-1:0]    dim_t;

  typedef struct packed {
    logic                       head;
    logic                       tail;
    logic [dest_info_width-1:0] dest;
    logic [lar_info_width-1:0]  lar;
  } flit_t;

  function automatic addr_t class_dest(input logic [dest_info_width-1:0] info, input rc_t rc);
    class_dest = '0;
    for (int c = 0; c < num_resource_classes; c++) begin
      if (rc == rc_t'(c))
        class_dest = info[c*router_addr_width +: router_addr_width];
    end
  endfunction

  logic [node_width_safe-1:0] node_addr;

  generate
    if (node_addr_width > 0) begin : g_node
      assign node_addr = in_dest_info[dest_info_width-1 -: node_addr_width];
    end else begin : g_no_node
      assign node_addr = '0;
    end
  endgenerate

  // ---- p0: next-hop address and lookahead route of the incoming flit ----
  port_t                     route_in;
  port_t                     route_p0;
  rc_t                       rc_in;
  rc_t                       rc_p0;
  addr_t                     next_addr;
  addr_t                     dest_p0;
  logic                      found;
  logic [lar_info_width-1:0] lar_p0;

  always_comb begin
    route_in  = in_lar_info[lar_info_width-1 -: port_width];
    rc_in     = in_lar_info[rc_width-1:0];
    next_addr = router_address;
    for (int d = 0; d < num_dimensions; d++) begin
      if (route_in == port_t'(2*d))
        next_addr[d*dim_addr_width +: dim_addr_width] =
          router_address[d*dim_addr_width +: dim_addr_width] - dim_t'(1);
      else if (route_in == port_t'(2*d+1))
        next_addr[d*dim_addr_width +: dim_addr_width] =
          router_address[d*dim_addr_width +: dim_addr_width] + dim_t'(1);
    end

    // Reaching an intermediate class destination moves the flit to the next phase.
    rc_p0   = rc_in;
    dest_p0 = class_dest(in_dest_info, rc_in);
    if (next_addr == dest_p0 && rc_in < rc_t'(num_resource_classes-1)) begin
      rc_p0   = rc_in + rc_t'(1);
      dest_p0 = class_dest(in_dest_info, rc_p0);
    end

    route_p0 = port_t'(2*num_dimensions) + port_t'(node_addr);
    found    = 1'b0;
    for (int d = 0; d < num_dimensions; d++) begin
      if (!found && next_addr[d*dim_addr_width +: dim_addr_width] !=
                    dest_p0[d*dim_addr_width +: dim_addr_width]) begin
        found    = 1'b1;
        route_p0 = port_t'(2*d) + port_t'(dest_p0[d*dim_addr_width +: dim_addr_width] >
                                           next_addr[d*dim_addr_width +: dim_addr_width]);
      end
    end

    lar_p0 = in_head ? {route_p0, rc_p0} : in_lar_info;
  end

  // ---- p1: output register with skid register behind it ----
  flit_t in_flit;
  flit_t flit_p1;
  flit_t skid_p1;
  logic  vld_p1;
  logic  skid_vld_p1;
  logic  rdy_p1;
  logic  accept;
  logic  drain;
  logic  load_out;

  assign in_flit  = {in_head, in_tail, in_dest_info, lar_p0};
  assign accept   = in_valid & rdy_p1;
  assign drain    = vld_p1 & out_ready;
  assign load_out = ~vld_p1 | drain;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b0;
      flit_p1     <= '0;
      skid_p1     <= '0;
    end else if (skid_vld_p1) begin
      // in_ready is low here, so nothing new can arrive while the skid drains.
      if (load_out) begin
        flit_p1     <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end
      rdy_p1 <= load_out;
    end else if (accept) begin
      if (load_out) begin
        flit_p1 <= in_flit;
        vld_p1  <= 1'b1;
        rdy_p1  <= 1'b1;
      end else begin
        skid_p1     <= in_flit;
        skid_vld_p1 <= 1'b1;
        rdy_p1      <= 1'b0;
      end
    end else begin
      if (drain)
        vld_p1 <= 1'b0;
      rdy_p1 <= 1'b1;
    end
  end

  assign in_ready      = rdy_p1;
  assign out_valid     = vld_p1;
  assign out_head      = flit_p1.head;
  assign out_tail      = flit_p1.tail;
  assign out_dest_info = flit_p1.dest;
  assign out_lar_info  = flit_p1.lar;

`ifdef RTR_LAR_PIPE_CHECK_EN
  typedef enum logic {IDLE, PKT} frame_state_t;

  frame_state_t state;
  frame_state_t state_next;
  logic         err_next;
  logic         err_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      err_p1 <= 1'b0;
    end else begin
      state  <= state_next;
      err_p1 <= err_next;
    end
  end

  // A head inside a packet is flagged, then treated as the start of a new packet.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (in_head)
            state_next = in_tail ? IDLE : PKT;
          else
            err_next = 1'b1;
        end
        PKT: begin
          if (in_head) begin
            err_next   = 1'b1;
            state_next = in_tail ? IDLE : PKT;
          end else if (in_tail) begin
            state_next = IDLE;
          end
        end
      endcase
    end
  end

  assign error = err_p1;
`else
  assign error = 1'b0;
`endif

endmodule
